// File: rtl/dma_rd_ctrl.sv
// -----------------------------------------------------------------------------
// dma_rd_ctrl
//   Read-side controller for the PL-to-CPU DMA async FIFO (64-bit read port),
//   running in the cpu_clk domain. It sequences the FIFO reset, waits for the
//   reset-busy flags to clear, then executes CPU-commanded transfers of N words.
//   Words read from the FIFO (1-cycle read latency) land in a 2-entry skid
//   buffer, and the head of that buffer is offered to the consumer with a
//   valid/ready handshake.
//
// Ports
//   cpu_clk, nreset                 clock, asynchronous active-low reset
//   ctrl_start, ctrl_len            start pulse and transfer length in words
//   ctrl_flush                      abort pulse; restarts the FIFO reset sequence
//   fifo_reset                      FIFO rst
//   fifo_rd_rst_busy/wr_rst_busy    FIFO reset-busy flags
//   fifo_empty, fifo_rd, fifo_dout  FIFO read port (dout valid cycle after rd)
//   dma_out, dma_valid, dma_re      consumer handshake (transfer on valid && re)
//   busy, done, words_done          progress / completion
//   status                          {rst_timeout, aborted, fifo_ready, dma_valid}
// -----------------------------------------------------------------------------
module dma_rd_ctrl #(
   parameter int LEN_W            = 16,
   parameter int RST_PULSE_CYCLES = 4,
   parameter int RST_TIMEOUT      = 256
) (
   input  logic             cpu_clk,
   input  logic             nreset,
   input  logic             ctrl_start,
   input  logic [LEN_W-1:0] ctrl_len,
   input  logic             ctrl_flush,
   output logic             fifo_reset,
   input  logic             fifo_rd_rst_busy,
   input  logic             fifo_wr_rst_busy,
   input  logic             fifo_empty,
   output logic             fifo_rd,
   input  logic [63:0]      fifo_dout,
   output logic [63:0]      dma_out,
   output logic             dma_valid,
   input  logic             dma_re,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_done,
   output logic [3:0]       status
);

   localparam int PCNT_W = $clog2(RST_PULSE_CYCLES + 1);
   localparam int TCNT_W = $clog2(RST_TIMEOUT + 1);
   localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(RST_TIMEOUT - 1);
   localparam logic [LEN_W-1:0]  ONE        = LEN_W'(1);

   typedef enum logic [1:0] {RST_PULSE, WAIT_BUSY, IDLE, RUN} state_t;

   state_t            state;
   logic [PCNT_W-1:0] pulse_cnt;
   logic [TCNT_W-1:0] tmo_cnt;
   logic              fifo_ready;
   logic              rst_timeout;
   logic              aborted;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued;
   logic              rd_p1;         // a FIFO read is in flight; dout valid now
   logic [1:0]        occ_p2;        // skid buffer occupancy
   logic [63:0]       skid_head_p2;
   logic [63:0]       skid_tail_p2;

   logic              pop;
   logic              push;
   logic              last_accept;
   logic [2:0]        fill;

   assign dma_valid = (occ_p2 != 2'd0);
   assign dma_out   = skid_head_p2;
   assign status    = {rst_timeout, aborted, fifo_ready, dma_valid};

   assign pop  = dma_valid && dma_re;
   assign push = rd_p1 && (state == RUN);

   // Projected occupancy once the in-flight word lands and this cycle's accept
   // leaves; a new read is only safe while that stays below the buffer depth.
   assign fill = {1'b0, occ_p2} + {2'b00, rd_p1} - {2'b00, pop};

   assign fifo_rd = (state == RUN) && !fifo_empty && (issued < len_q) && (fill < 3'd2);

   assign last_accept = (state == RUN) && pop && (words_done == len_q - ONE);

   always_ff @(posedge cpu_clk or negedge nreset) begin
      if (!nreset) begin
         state        <= RST_PULSE;
         pulse_cnt    <= '0;
         tmo_cnt      <= '0;
         fifo_reset   <= 1'b1;
         busy         <= 1'b1;
         fifo_ready   <= 1'b0;
         rst_timeout  <= 1'b0;
         aborted      <= 1'b0;
         len_q        <= '0;
         issued       <= '0;
         words_done   <= '0;
         done         <= 1'b0;
         rd_p1        <= 1'b0;
         occ_p2       <= 2'd0;
         skid_head_p2 <= '0;
         skid_tail_p2 <= '0;
      end else begin
         done  <= 1'b0;
         rd_p1 <= fifo_rd;

         // ---- stage p1 -> p2: capture FIFO data into the skid buffer ----
         if (state == RUN) begin
            if (pop)     words_done <= words_done + ONE;
            if (fifo_rd) issued     <= issued + ONE;
            case ({pop, push})
               2'b10: begin
                  skid_head_p2 <= skid_tail_p2;
                  occ_p2       <= occ_p2 - 2'd1;
               end
               2'b01: begin
                  if (occ_p2 == 2'd0) skid_head_p2 <= fifo_dout;
                  else                skid_tail_p2 <= fifo_dout;
                  occ_p2 <= occ_p2 + 2'd1;
               end
               2'b11: begin
                  if (occ_p2 == 2'd1) begin
                     skid_head_p2 <= fifo_dout;
                  end else begin
                     skid_head_p2 <= skid_tail_p2;
                     skid_tail_p2 <= fifo_dout;
                  end
               end
               default: ;
            endcase
         end

         // All words issued have been accepted, so the buffer is already empty.
         if (last_accept) begin
            done   <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
            occ_p2 <= 2'd0;
         end

         // Flush overrides every transition below, including a same-cycle start;
         // a word accepted in the flush cycle still counts.
         if (ctrl_flush) begin
            state       <= RST_PULSE;
            pulse_cnt   <= '0;
            fifo_reset  <= 1'b1;
            busy        <= 1'b1;
            fifo_ready  <= 1'b0;
            rst_timeout <= 1'b0;
            occ_p2      <= 2'd0;
            rd_p1       <= 1'b0;
            if (state == RUN && !last_accept) aborted <= 1'b1;
         end else begin
            case (state)
               RST_PULSE: begin
                  if (pulse_cnt == PULSE_LAST) begin
                     state      <= WAIT_BUSY;
                     fifo_reset <= 1'b0;
                     tmo_cnt    <= '0;
                  end else begin
                     pulse_cnt <= pulse_cnt + PCNT_W'(1);
                  end
               end
               WAIT_BUSY: begin
                  if (!fifo_rd_rst_busy && !fifo_wr_rst_busy) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     fifo_ready <= 1'b1;
                  end else if (tmo_cnt == TMO_LAST) begin
                     state       <= IDLE;
                     busy        <= 1'b0;
                     rst_timeout <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + TCNT_W'(1);
                  end
               end
               IDLE: begin
                  if (ctrl_start && fifo_ready) begin
                     words_done <= '0;
                     if (ctrl_len == '0) begin
                        done <= 1'b1;
                     end else begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        len_q   <= ctrl_len;
                        issued  <= '0;
                        aborted <= 1'b0;
                     end
                  end
               end
               RUN: ;
            endcase
         end
      end
   end

endmodule
